// File: rtl/param_reg_file.sv
// param_reg_file: parametrised register file with one write port and two
// registered read ports (A/B), a read-valid strobe, an optional hardwired-zero
// entry 0, and a sequential clear sweep (after reset or on request) with busy.
// Optional feature macro: REGFILE_BYPASS_EN (write-first same-edge read when
// defined; read-first when undefined).
module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int SEL_W    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              write,
  input  logic [SEL_W-1:0]  selectW1,
  input  logic [DATA_W-1:0] dataW,
  input  logic              read,
  input  logic [SEL_W-1:0]  selectR1,
  input  logic [SEL_W-1:0]  selectR2,
  input  logic              clr,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB,
  output logic              outValid,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              rd_ok;
  logic [AW-1:0]     widx;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // A write lands only for an in-range index and never on a hardwired-zero entry 0.
  function automatic logic wr_allowed(input logic [SEL_W-1:0] idx);
    logic ok;
    ok = (32'(idx) < DEPTH);
    if (ZERO_REG != 0 && idx == '0) ok = 1'b0;
    return ok;
  endfunction

  // Read word for one port: out-of-range and hardwired-zero indices read 0;
  // with bypass, a same-edge accepted write to the index is forwarded.
  function automatic logic [DATA_W-1:0] rd_word(input logic [SEL_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = mem[idx[AW-1:0]];
    if (32'(idx) >= DEPTH) v = '0;
    else if (ZERO_REG != 0 && idx == '0) v = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wr_ok && idx == selectW1) v = dataW;
`endif
    return v;
  endfunction

  // Decode of accepted write/read requests and combinational read data.
  always_comb begin
    wr_ok = EN && write && !busy && wr_allowed(selectW1);
    rd_ok = EN && read && !busy;
    widx  = selectW1[AW-1:0];
    rd_a  = rd_word(selectR1);
    rd_b  = rd_word(selectR2);
  end

  // Sweep FSM: reset parks it in CLEAR at entry 0; clr from IDLE restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (EN && clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage: the sweep owns the array while busy, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) mem[ptr] <= '0;
      else if (wr_ok) mem[widx] <= dataW;
    end
  end

  // Registered read ports: update on an accepted read, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      outA     <= '0;
      outB     <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= rd_ok;
      if (rd_ok) begin
        outA <= rd_a;
        outB <= rd_b;
      end
    end
  end

endmodule
